// File: rtl/audio_clk_switch_fsm_if.sv
// Handshake bundle between the synchronizer side and the audio clock switch controller.
// The controller side uses the slave modport.
interface audio_clk_switch_fsm_if;
  logic en_sync;
  logic sel_sync;
  logic clk_sel;
  logic gate_en;
  logic mute;
  logic busy;
  logic switch_done;

  modport master (
    output en_sync,
    output sel_sync,
    input  clk_sel,
    input  gate_en,
    input  mute,
    input  busy,
    input  switch_done
  );

  modport slave (
    input  en_sync,
    input  sel_sync,
    output clk_sel,
    output gate_en,
    output mute,
    output busy,
    output switch_done
  );
endinterface

// File: rtl/audio_clk_switch_fsm.sv
// Debounces the synchronized enable/select levels and sequences a click-free MCLK change:
// mute, gate off, switch select, settle, gate on, unmute.
module audio_clk_switch_fsm #(
  parameter int unsigned STABLE_CYCLES   = 4,
  parameter int unsigned MUTE_CYCLES     = 32,
  parameter int unsigned GATE_OFF_CYCLES = 8,
  parameter int unsigned SETTLE_CYCLES   = 64
) (
  input logic                   clk,
  input logic                   reset,
  audio_clk_switch_fsm_if.slave bus
);

  localparam int unsigned MaxMg   = (MUTE_CYCLES > GATE_OFF_CYCLES) ? MUTE_CYCLES
                                                                    : GATE_OFF_CYCLES;
  localparam int unsigned MaxWait = (MaxMg > SETTLE_CYCLES) ? MaxMg : SETTLE_CYCLES;
  localparam int unsigned TimerW  = $clog2(MaxWait) + 1;
  localparam int unsigned DbW     = $clog2(STABLE_CYCLES) + 1;

  localparam logic [DbW-1:0]    DbLast     = DbW'(STABLE_CYCLES - 1);
  localparam logic [TimerW-1:0] MuteLoad   = TimerW'(MUTE_CYCLES - 1);
  localparam logic [TimerW-1:0] GateLoad   = TimerW'(GATE_OFF_CYCLES - 1);
  localparam logic [TimerW-1:0] SettleLoad = TimerW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {StOff, StSelect, StSettle, StRun, StMute, StGateOff} state_e;

  state_e              state_q, state_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic                filt_en_q, filt_en_d;
  logic                filt_sel_q, filt_sel_d;
  logic [DbW-1:0]      en_cnt_q, en_cnt_d;
  logic [DbW-1:0]      sel_cnt_q, sel_cnt_d;
  logic                clk_sel_q, clk_sel_d;
  logic                gate_en_q, gate_en_d;
  logic                mute_q, mute_d;
  logic                busy_q, busy_d;
  logic                switch_done_q, switch_done_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StOff;
      timer_q       <= '0;
      filt_en_q     <= 1'b0;
      filt_sel_q    <= 1'b0;
      en_cnt_q      <= '0;
      sel_cnt_q     <= '0;
      clk_sel_q     <= 1'b0;
      gate_en_q     <= 1'b0;
      mute_q        <= 1'b1;
      busy_q        <= 1'b0;
      switch_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      filt_en_q     <= filt_en_d;
      filt_sel_q    <= filt_sel_d;
      en_cnt_q      <= en_cnt_d;
      sel_cnt_q     <= sel_cnt_d;
      clk_sel_q     <= clk_sel_d;
      gate_en_q     <= gate_en_d;
      mute_q        <= mute_d;
      busy_q        <= busy_d;
      switch_done_q <= switch_done_d;
    end
  end

  // A new level is accepted on the STABLE_CYCLES-th consecutive differing sample.
  always_comb begin
    filt_en_d  = filt_en_q;
    en_cnt_d   = '0;
    filt_sel_d = filt_sel_q;
    sel_cnt_d  = '0;
    if (bus.en_sync != filt_en_q) begin
      if (en_cnt_q == DbLast) filt_en_d = bus.en_sync;
      else                    en_cnt_d  = en_cnt_q + 1'b1;
    end
    if (bus.sel_sync != filt_sel_q) begin
      if (sel_cnt_q == DbLast) filt_sel_d = bus.sel_sync;
      else                     sel_cnt_d  = sel_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      StOff: begin
        if (filt_en_q) state_d = StSelect;
      end
      StSelect: begin
        state_d = StSettle;
        timer_d = SettleLoad;
      end
      StSettle: begin
        if (timer_q == '0) state_d = StRun;
        else               timer_d = timer_q - 1'b1;
      end
      StRun: begin
        // Disable and select change share the same exit path; disable wins at GATE_OFF exit.
        if (!filt_en_q || (filt_sel_q != clk_sel_q)) begin
          state_d = StMute;
          timer_d = MuteLoad;
        end
      end
      StMute: begin
        if (timer_q == '0) begin
          state_d = StGateOff;
          timer_d = GateLoad;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      StGateOff: begin
        if (timer_q == '0) state_d = filt_en_q ? StSelect : StOff;
        else               timer_d = timer_q - 1'b1;
      end
      default: state_d = StOff;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    clk_sel_d     = (state_d == StSelect) ? filt_sel_q : clk_sel_q;
    gate_en_d     = (state_d == StSettle) || (state_d == StRun) || (state_d == StMute);
    mute_d        = (state_d != StRun);
    busy_d        = (state_d != StOff) && (state_d != StRun);
    switch_done_d = (state_d == StRun) && (state_q != StRun);
  end

  assign bus.clk_sel     = clk_sel_q;
  assign bus.gate_en     = gate_en_q;
  assign bus.mute        = mute_q;
  assign bus.busy        = busy_q;
  assign bus.switch_done = switch_done_q;

endmodule

// File: tb/tb_audio_clk_switch_fsm.sv
// Bench for audio_clk_switch_fsm: directed scenarios plus random stimulus against a
// schedule-based model that expands each switch sequence into per-cycle expected outputs.
module tb_audio_clk_switch_fsm;

  localparam int unsigned Stable = 4;
  localparam int unsigned Mute   = 32;
  localparam int unsigned Goff   = 8;
  localparam int unsigned Settle = 64;

  localparam logic [1:0] KOff = 2'd0, KRun = 2'd1, KGEnd = 2'd2, KSeq = 2'd3;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  audio_clk_switch_fsm_if bus ();

  audio_clk_switch_fsm #(
    .STABLE_CYCLES  (Stable),
    .MUTE_CYCLES    (Mute),
    .GATE_OFF_CYCLES(Goff),
    .SETTLE_CYCLES  (Settle)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // One planned output cycle: {clk_sel, gate_en, mute, busy, switch_done} plus what follows it.
  typedef struct packed {
    logic [4:0] out;
    logic [1:0] tag;
  } ent_t;

  ent_t       plan[$];
  logic [1:0] kind;
  logic       m_cs, m_fen, m_fsel;
  int         m_cen, m_csel;
  logic [4:0] m_out;

  function automatic logic [4:0] dv();
    return {bus.clk_sel, bus.gate_en, bus.mute, bus.busy, bus.switch_done};
  endfunction

  task automatic push_select(input logic s);
    plan.push_back('{out: {s, 4'b0110}, tag: KSeq});
    repeat (Settle) plan.push_back('{out: {s, 4'b1110}, tag: KSeq});
    plan.push_back('{out: {s, 4'b1001}, tag: KRun});
  endtask

  task automatic push_mute();
    repeat (Mute) plan.push_back('{out: {m_cs, 4'b1110}, tag: KSeq});
    repeat (Goff - 1) plan.push_back('{out: {m_cs, 4'b0110}, tag: KSeq});
    plan.push_back('{out: {m_cs, 4'b0110}, tag: KGEnd});
  endtask

  // Advances the model across one rising edge using the levels presented before it.
  task automatic model_edge();
    ent_t e;
    if (reset) begin
      plan.delete();
      kind  = KOff;
      m_cs  = 1'b0;
      m_out = 5'b00100;
      m_fen = 1'b0;
      m_fsel = 1'b0;
      m_cen = 0;
      m_csel = 0;
      return;
    end
    if (plan.size() == 0) begin
      case (kind)
        KOff:  if (m_fen) push_select(m_fsel);
        KRun:  if (!m_fen || (m_fsel != m_cs)) push_mute();
        KGEnd: if (m_fen) push_select(m_fsel); else kind = KOff;
        default: ;
      endcase
    end
    if (plan.size() > 0) begin
      e     = plan.pop_front();
      m_out = e.out;
      m_cs  = e.out[4];
      kind  = e.tag;
    end else begin
      m_out = {m_cs, kind == KRun, kind != KRun, 2'b00};
    end
    if (bus.en_sync != m_fen) begin
      m_cen++;
      if (m_cen == Stable) begin m_fen = bus.en_sync; m_cen = 0; end
    end else m_cen = 0;
    if (bus.sel_sync != m_fsel) begin
      m_csel++;
      if (m_csel == Stable) begin m_fsel = bus.sel_sync; m_csel = 0; end
    end else m_csel = 0;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.en_sync = 1'b1;
    bus.sel_sync = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++;
      if (dv() !== 5'b00100) begin
        errors++;
        $display("FAIL reset k=%0d got=%b want=%b", k, dv(), 5'b00100);
      end
    end
  endtask

  task automatic test_startup();
    logic [4:0] want;
    reset = 1'b0;
    bus.en_sync = 1'b1;
    bus.sel_sync = 1'b0;
    for (int k = 1; k <= 75; k++) begin
      step();
      want = {1'b0, k >= 6, k < 70, (k >= 5) && (k <= 69), k == 70};
      checks++;
      if (dv() !== want) begin
        errors++;
        $display("FAIL startup_timing k=%0d got=%b want=%b", k, dv(), want);
      end
      checks++;
      if (dv() !== m_out) begin
        errors++;
        $display("FAIL startup_model k=%0d got=%b want=%b", k, dv(), m_out);
      end
    end
  endtask

  task automatic test_family_switch();
    logic [4:0] want;
    logic       pcs, pg;
    pcs = bus.clk_sel;
    pg  = bus.gate_en;
    bus.sel_sync = 1'b1;
    for (int k = 1; k <= 115; k++) begin
      step();
      want = {k >= 45, !((k >= 37) && (k <= 45)), (k >= 5) && (k < 110),
              (k >= 5) && (k <= 109), k == 110};
      checks++;
      if (dv() !== want) begin
        errors++;
        $display("FAIL family_timing k=%0d got=%b want=%b", k, dv(), want);
      end
      checks++;
      if ((bus.clk_sel !== pcs) && (pg || bus.gate_en)) begin
        errors++;
        $display("FAIL family_gate_safe k=%0d got gate=%b/%b want 0/0", k, pg, bus.gate_en);
      end
      pcs = bus.clk_sel;
      pg  = bus.gate_en;
    end
  endtask

  task automatic test_glitch();
    for (int k = 1; k <= 20; k++) begin
      bus.sel_sync = (k <= 3) ? 1'b0 : 1'b1;
      bus.en_sync  = ((k >= 6) && (k <= 8)) ? 1'b0 : 1'b1;
      step();
      checks++;
      if (dv() !== 5'b11000) begin
        errors++;
        $display("FAIL glitch k=%0d got=%b want=%b", k, dv(), 5'b11000);
      end
      checks++;
      if (dv() !== m_out) begin
        errors++;
        $display("FAIL glitch_model k=%0d got=%b want=%b", k, dv(), m_out);
      end
    end
  endtask

  task automatic test_disable_priority();
    int dones = 0;
    bus.sel_sync = 1'b0;
    bus.en_sync  = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      step();
      dones += int'(bus.switch_done);
      checks++;
      if (dv() !== m_out) begin
        errors++;
        $display("FAIL disable_model k=%0d got=%b want=%b", k, dv(), m_out);
      end
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL disable_done got=%0d want=0", dones);
    end
    checks++;
    if (dv() !== 5'b10100) begin
      errors++;
      $display("FAIL disable_final got=%b want=%b", dv(), 5'b10100);
    end
  endtask

  task automatic test_rerequest();
    int dones;
    bus.en_sync  = 1'b1;
    bus.sel_sync = 1'b0;
    for (int k = 1; k <= 75; k++) begin
      step();
      checks++;
      if (dv() !== m_out) begin
        errors++;
        $display("FAIL rereq_warm_model k=%0d got=%b want=%b", k, dv(), m_out);
      end
    end
    // Select goes away and comes back while the sequence is in MUTE.
    dones = 0;
    for (int k = 1; k <= 115; k++) begin
      bus.sel_sync = ((k >= 1) && (k < 10)) ? 1'b1 : 1'b0;
      step();
      dones += int'(bus.switch_done);
      checks++;
      if (bus.clk_sel !== 1'b0 || dv() !== m_out) begin
        errors++;
        $display("FAIL rereq_back k=%0d got=%b want=%b", k, dv(), m_out);
      end
    end
    checks++;
    if (dones != 1 || dv() !== 5'b01000) begin
      errors++;
      $display("FAIL rereq_back_end got=%0d,%b want=1,%b", dones, dv(), 5'b01000);
    end
    // Enable drops during SETTLE: one RUN cycle, then back down to OFF.
    dones = 0;
    bus.sel_sync = 1'b1;
    for (int k = 1; k <= 160; k++) begin
      if (k == 60) bus.en_sync = 1'b0;
      step();
      dones += int'(bus.switch_done);
      checks++;
      if (dv() !== m_out) begin
        errors++;
        $display("FAIL rereq_settle_model k=%0d got=%b want=%b", k, dv(), m_out);
      end
      if (k == 110) begin
        checks++;
        if (dv() !== 5'b11001) begin
          errors++;
          $display("FAIL rereq_run_pulse got=%b want=%b", dv(), 5'b11001);
        end
      end
    end
    checks++;
    if (dones != 1 || dv() !== 5'b10100) begin
      errors++;
      $display("FAIL rereq_settle_end got=%0d,%b want=1,%b", dones, dv(), 5'b10100);
    end
  endtask

  task automatic test_reset_mid();
    bus.en_sync  = 1'b1;
    bus.sel_sync = 1'b1;
    repeat (75) step();
    bus.sel_sync = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 40) reset = 1'b1;
      step();
    end
    checks++;
    if (dv() !== 5'b00100) begin
      errors++;
      $display("FAIL reset_mid got=%b want=%b", dv(), 5'b00100);
    end
    test_startup();
  endtask

  task automatic test_random();
    logic pcs, pg, prst;
    pcs  = bus.clk_sel;
    pg   = bus.gate_en;
    prst = 1'b0;
    for (int k = 1; k <= 4000; k++) begin
      reset = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 15) == 0) bus.en_sync = ~bus.en_sync;
      if ($urandom_range(0, 11) == 0) bus.sel_sync = ~bus.sel_sync;
      step();
      checks++;
      if (dv() !== m_out) begin
        errors++;
        $display("FAIL random_model k=%0d got=%b want=%b", k, dv(), m_out);
      end
      if (!reset && !prst) begin
        checks++;
        if ((bus.clk_sel !== pcs) && (pg || bus.gate_en)) begin
          errors++;
          $display("FAIL random_gate_safe k=%0d got gate=%b/%b want 0/0", k, pg, bus.gate_en);
        end
      end
      prst = reset;
      pcs  = bus.clk_sel;
      pg   = bus.gate_en;
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_startup();
    test_family_switch();
    test_glitch();
    test_disable_priority();
    test_rerequest();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_clk_switch_fsm.md
Name: audio_clk_switch_fsm

Overview:
- Control stage fed directly by the two-signal two-flop synchronizer in audio_clk_mux.
- Takes the already-synchronized audio-enable and MCLK-family-select levels and debounces them.
- Sequences a glitch-free, click-free change of the audio master clock: mute, gate off, switch select, settle, gate on, unmute.
- Drives the clock-mux select, the clock-gate enable and the DAC mute.

Parameters:
STABLE_CYCLES, 4, consecutive cycles a synchronized input must hold a new value before it is accepted (>=1)
MUTE_CYCLES, 32, cycles mute is asserted before the clock gate is dropped (>=1)
GATE_OFF_CYCLES, 8, cycles the gate is held off before/after the select changes (>=1)
SETTLE_CYCLES, 64, cycles after gate-on before unmute (>=1)

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
en_sync  input  1  synchronized audio enable (from synchronizer sig1_out)
sel_sync  input  1  synchronized MCLK family select, 0=44.1k, 1=48k (from sig2_out)
clk_sel  output  1  registered select to the clock mux
gate_en  output  1  registered clock-gate enable
mute  output  1  registered DAC mute, 1=muted
busy  output  1  high in any state other than OFF and RUN
switch_done  output  1  one-cycle pulse on entry to RUN

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset; it is sampled only on the rising edge of clk.
- Reset values: clk_sel=0, gate_en=0, mute=1, busy=0, switch_done=0, filt_en=0, filt_sel=0, state=OFF, all counters 0.
- Reset mid-sequence aborts immediately to OFF with the above values.
- Debounce: each input has its own filter (filt_en, filt_sel) and its own counter.
  - If input == filt, the counter clears.
  - Otherwise the counter increments. When the counter == STABLE_CYCLES-1 and the input still differs, filt takes the input and the counter clears.
  - Net effect: filt changes exactly STABLE_CYCLES edges after the first differing sample. A pulse shorter than STABLE_CYCLES never propagates.
- State timing: wait states hold exactly N cycles using a shared down-counter, loaded on state entry.
- OFF: gate_en=0, mute=1. If filt_en=1, go to SELECT.
- SELECT (1 cycle): clk_sel<=filt_sel; gate_en stays 0. Go to SETTLE.
- SETTLE (SETTLE_CYCLES): gate_en=1, mute=1. Go to RUN.
- RUN: mute=0, gate_en=1. switch_done=1 on the entry cycle only.
  - If filt_en=0, go to MUTE.
  - Else if filt_sel != clk_sel, go to MUTE.
  - A disable request takes priority over a select change.
- MUTE (MUTE_CYCLES): mute=1, gate_en=1. Go to GATE_OFF.
- GATE_OFF (GATE_OFF_CYCLES): gate_en=0, mute=1. On exit:
  - filt_en=0 → OFF;
  - else → SELECT, using the latest filt_sel.
- Requests during MUTE/GATE_OFF/SELECT/SETTLE are not acted on mid-sequence. They are re-evaluated at GATE_OFF exit and at RUN.
- A select toggling back to the current clk_sel during MUTE/GATE_OFF still completes the sequence (SELECT reloads the same value).
- clk_sel changes only in SELECT, always with gate_en=0 for at least GATE_OFF_CYCLES before the change and at least 1 cycle after it.
- gate_en never toggles while mute=0. mute falls only on entry to RUN.
- Counter width is $clog2 of the largest of the wait parameters, plus 1.

Test Plan:
- Startup: release reset with en_sync=1, sel_sync=0 held → filt_en rises 4 cycles later; SELECT 1 cycle; gate_en=1 for 64 cycles with mute=1; then mute=0 with a single switch_done pulse. busy is high from SELECT through SETTLE.
- Family switch: in RUN, set sel_sync 0→1 → after 4 cycles mute=1 for 32 cycles; gate_en=0 for 8 cycles; clk_sel=1 in SELECT; 64 settle cycles; RUN with switch_done pulse. Checker: clk_sel never changes while gate_en=1.
- Glitch rejection: in RUN, 3-cycle pulse on sel_sync, then a 3-cycle pulse on en_sync → no state change, mute stays 0, busy stays 0.
- Disable priority: in RUN, change sel_sync and drop en_sync on the same cycle → MUTE, GATE_OFF, then OFF. clk_sel is unchanged, gate_en=0, mute=1, no switch_done.
- Re-request mid-sequence: during MUTE, return sel_sync to 0 (filt_sel=0) → sequence completes via SELECT with clk_sel=0, ending in RUN. Separately, drop en_sync during SETTLE → RUN (1 cycle, switch_done), then MUTE→GATE_OFF→OFF.
- Reset mid-operation: assert reset during GATE_OFF → next edge clk_sel=0, gate_en=0, mute=1, busy=0, state OFF. On release, restart as in the startup scenario.
